uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit-side frame sequencer for the UART.
- Accepts a byte over a valid/ready handshake and serialises it on the tx line as start, data (LSB first), optional parity and stop bits.
- Every bit boundary is paced by the one-cycle tick pulse from the free-running baud generator.
- Sits between the host-side byte source and the tx pin; it does not generate baud timing itself.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  baud pulse: high for one clk cycle once per bit period.
- in_data  input  DATA_BITS  byte to transmit; sampled only on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high: the block acts on reset only at a rising clk edge.
  - Reset values: state = IDLE, tx = 1, in_ready = 1, busy = 0, done = 0, shift register = 0, bit counter = 0.
  - Reset asserted mid-frame aborts the frame. On the next edge, tx = 1 and the state is IDLE; no done pulse is produced.
- Registers
  - All outputs are registered.
  - tx changes only on an edge where tick = 1, or on reset.
- Accept
  - A byte is accepted on an edge where in_valid && in_ready.
  - in_data is latched into the shift register and the state moves to ARM.
  - in_ready drops on that same edge.
  - in_data is don't-care after accept.
- States
  - IDLE: tx = 1. Ticks are ignored.
  - ARM: wait for the next tick; on it, go to START and set tx = 0. This aligns the frame to the free-running tick so every bit lasts exactly one tick period. Accept-to-start-bit latency is 1..CLK_PER_BIT clocks.
  - START: on tick, go to DATA, tx = shreg[0], counter = 0.
  - DATA: on each tick, shift right. tx = next bit. The counter increments.
    - When counter == DATA_BITS-1 and tick = 1, go to PARITY if parity is compiled in, else STOP.
    - tx = parity or 1 accordingly.
  - PARITY: on tick, go to STOP, tx = 1.
  - STOP: counts STOP_BITS ticks with tx = 1. On the last tick: go to IDLE, done = 1 for one cycle, in_ready = 1.
- Back-to-back frames
  - A byte presented while done is high is accepted on the following edge (in_ready is high then).
  - The ARM wait then inserts at least one full bit of idle between frames. This is required behaviour.
- Boundary cases
  - in_valid high with in_ready low: ignored, with no side effects.
  - tick in the same cycle as accept: not consumed. ARM waits for the next tick.
  - A tick missing for many cycles: the block holds its state indefinitely.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: PARITY state present. The parity bit is the XOR of the data bits; it is inverted if PARITY_ODD = 1. Frame length = 1 + DATA_BITS + 1 + STOP_BITS ticks.
- Undefined: PARITY state, parity logic and the PARITY_ODD effect are absent. DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, ARM, START, DATA, PARITY, STOP;
  - constants for the idle line level (1) and start bit level (0);
  - the default CLK_PER_BIT value, shared with the baud generator.
- No sub-module: the FSM, shift register and counter stay in one module. The baud generator is instantiated beside it, not inside it.

Test Plan:
- Reset release, no input: tx = 1, in_ready = 1, busy = 0 for 100 cycles, with ticks running.
- Bench uses a tick every 16 clks. Send 0xA5, parity off, STOP_BITS = 1.
  - Required tx sequence, one bit per tick period: 0, 1,0,1,0,0,1,0,1, 1.
  - done pulses once, 160 clks after the start bit begins.
- UART_PARITY_EN with PARITY_ODD = 0: send 0x07 -> parity bit = 1. With PARITY_ODD = 1: parity bit = 0.
- Back-to-back: hold in_valid high with 0x55 then 0xAA.
  - Both frames are correct.
  - The second start bit begins at least 16 clks after the first frame's stop bit ends.
  - in_ready is low throughout both frames.
- Assert reset during DATA bit 3: next edge gives tx = 1, state IDLE, no done pulse. A subsequent send of 0x3C is correct.
- Assert in_valid on the same cycle as a tick: the start bit begins on the next tick, not the current one; bit width = 16 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer states, line levels and the
// default bit period used by the baud generator that paces the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int CLK_PER_BIT_DEF = 16;

endpackage : uart_pkg

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_BITS data (LSB first), optional
// parity (macro UART_PARITY_EN), STOP_BITS stop bits, each paced by tick.
//
// state  | meaning
// IDLE   | line high, waiting for a byte; ticks ignored
// ARM    | byte latched, waiting for next tick to align the frame
// START  | start bit on the line
// DATA   | data bits on the line, LSB first
// PARITY | parity bit on the line (UART_PARITY_EN only)
// STOP   | stop bit(s) on the line
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_ctrl: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_ctrl: PARITY_ODD must be 0 or 1");
    end

    uart_state_t            r_state;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stop_cnt;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
`ifdef UART_PARITY_EN
    logic                   r_parity;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= LINE_IDLE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= LINE_IDLE;
                    if (in_valid && r_ready) begin
                        r_shreg <= in_data;
`ifdef UART_PARITY_EN
                        r_parity <= (^in_data) ^ 1'(PARITY_ODD);
`endif
                        r_state <= ARM;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                // A tick on the accept edge is seen in IDLE and so never starts the frame.
                ARM: begin
                    if (tick) begin
                        r_state <= START;
                        r_tx    <= LINE_START;
                    end
                end
                START: begin
                    if (tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                        r_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (r_cnt == LAST_BIT) begin
                            r_stop_cnt <= 1'b0;
`ifdef UART_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= LINE_IDLE;
`endif
                        end else begin
                            r_tx    <= r_shreg[0];
                            r_shreg <= r_shreg >> 1;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        r_state <= STOP;
                        r_tx    <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= LINE_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: tick every 16 clks, frames checked bit by bit.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int phase    = 0;

    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
        .clk(clk), .reset(reset), .tick(tick), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
    );

`ifdef UART_PARITY_EN
    logic in_ready_odd, tx_odd, busy_odd, done_odd;
    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut_odd (
        .clk(clk), .reset(reset), .tick(tick), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_odd), .tx(tx_odd), .busy(busy_odd), .done(done_odd)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 16;
            tick  = (phase == 0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input string tag, output int s);
        s = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (tx === 1'b0) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        acc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expects the byte already accepted; checks each bit at both ends of its period.
    task automatic check_frame(input logic [7:0] b, input string tag, output int s, output int d);
        logic exp_bits [0:10];
        logic exp_odd  [0:10];
        int   n;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef UART_PARITY_EN
        exp_bits[9]  = ^b;
        exp_bits[10] = 1'b1;
        n = 11;
`else
        exp_bits[9]  = 1'b1;
        exp_bits[10] = 1'b1;
        n = 10;
`endif
        for (int i = 0; i < 11; i++) exp_odd[i] = exp_bits[i];
        exp_odd[9] = (n == 11) ? ~(^b) : 1'b1;
        wait_start(tag, s);
        d = -1;
        if (s < 0) return;
        for (int k = 0; k < n; k++) begin
            wait_to(s + 16 * k);
            chk($sformatf("%s_bit%0d_head", tag, k), tx, exp_bits[k]);
            chk($sformatf("%s_bit%0d_ready", tag, k), in_ready, 1'b0);
            chk($sformatf("%s_bit%0d_busy", tag, k), busy, 1'b1);
`ifdef UART_PARITY_EN
            chk($sformatf("%s_odd_bit%0d", tag, k), tx_odd, exp_odd[k]);
`endif
            wait_to(s + 16 * k + 15);
            chk($sformatf("%s_bit%0d_tail", tag, k), tx, exp_bits[k]);
            chk($sformatf("%s_bit%0d_nodone", tag, k), done, 1'b0);
        end
        d = s + 16 * n;
        wait_to(d);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_done_ready"}, in_ready, 1'b1);
        chk({tag, "_done_busy"}, busy, 1'b0);
        chk({tag, "_done_tx"}, tx, 1'b1);
        wait_to(d + 1);
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int acc, s, d, s2, d2, dn;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 9) begin
                chk("idle_tx", tx, 1'b1);
                chk("idle_ready", in_ready, 1'b1);
                chk("idle_busy", busy, 1'b0);
                chk("idle_done", done, 1'b0);
            end
        end

        // 0xA5: line reads 0,1,0,1,0,0,1,0,1,(parity),1
        send(8'hA5, acc);
        check_frame(8'hA5, "a5", s, d);
        chk("a5_done_at_160", d - s, (`ifdef UART_PARITY_EN 176 `else 160 `endif));

`ifdef UART_PARITY_EN
        send(8'h07, acc);
        check_frame(8'h07, "par07", s, d);
`endif

        // Back-to-back with in_valid held high across both frames
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("b2b_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_data = 8'hAA;
        check_frame(8'h55, "b2b1", s, d);
        chk("b2b_second_accepted", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_frame(8'hAA, "b2b2", s2, d2);
        chk("b2b_gap_ge16", ((s2 - d) >= 16) ? 1 : 0, 1);

        // Reset during data bit 3 aborts without a done pulse
        send(8'hF0, acc);
        wait_start("abort", s);
        wait_to(s + 16 * 4 + 8);
        chk("abort_pre_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
            if (!tx) dn += 100;
        end
        chk("abort_no_done_quiet_line", dn, 0);
        send(8'h3C, acc);
        check_frame(8'h3C, "after_abort", s, d);

        // Accept on the same edge as a tick: start waits for the next tick
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (tick) break;
        end
        in_valid = 1'b1;
        in_data  = 8'h81;
        @(posedge clk);
        #1;
        acc = cyc;
        chk("tickacc_accepted", in_ready, 1'b0);
        chk("tickacc_tx_still_idle", tx, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_frame(8'h81, "tickacc", s, d);
        chk("tickacc_latency", s - acc, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
